pwm_duty_ramp: RTL and testbench
================================

# pwm_duty_ramp

Soft-start / soft-stop duty-cycle sequencer that sits directly upstream of the PWM generator and drives its 7-bit duty-percent input. It synchronizes the asynchronous pad inputs and steps the output duty one percent at a time toward a requested target at a programmable rate. Every duty update lands on a PWM period boundary, so the downstream generator never sees a mid-period change.

## Interface

Parameters:
- PERIOD_BITS, 8: width of the free-running period counter; one PWM period is 2^PERIOD_BITS cycles. This must match the downstream counter width.
- RATE_BITS, 3: width of the rate input. The step interval is 2^rate periods.

Ports:
- clk, input, 1: single system clock.
- rst_n, input, 1: reset, asynchronous and active-low.
- target, input, 7: requested duty in percent, asynchronous to clk. Values above 100 are clamped to 100.
- rate, input, RATE_BITS: step interval selector; one step every 2^rate periods. Asynchronous to clk.
- enable, input, 1: when 0, the effective target is 0 (soft stop). Asynchronous to clk.
- kill, input, 1: emergency stop, asynchronous to clk. Forces dc to 0 immediately.
- dc, output, 7: current duty percent, range 0..100, registered.
- period_start, output, 1: one-cycle pulse in the first cycle of each period, registered.
- busy, output, 1: high while in UP or DOWN, registered.
- at_target, output, 1: high when dc equals the effective target, registered.

## Operation

Input synchronization:
- target, rate, enable and kill each pass through a 2-flop synchronizer (all flops reset to 0).
- The signals below use the synchronized values target_s, rate_s, enable_s and kill_s.

Effective target:
- eff = enable_s ? min(target_s, 100) : 0.
- Compare at 7 bits, unsigned.

Period counter and tick:
- The period counter is PERIOD_BITS wide, free-running from 0 after reset and wrapping from max to 0.
- A "tick" is the edge where the counter wraps from max to 0.
- All dc changes, apart from kill, occur only on ticks.

Step counter:
- Width is 2^RATE_BITS - 1 bits, enough to hold 2^rate - 1.
- A "step threshold" is reached when the step counter equals 2^rate_s - 1, evaluated at the tick.

State machine (IDLE, UP, DOWN), evaluated at each tick:
- **IDLE:**
  - If eff > dc, go to UP.
  - If eff < dc, go to DOWN.
  - Otherwise stay in IDLE.
  - The step counter clears to 0 and dc does not change on this tick.
- **UP:**
  - If eff < dc, go to DOWN and clear the step counter; dc is unchanged.
  - Else if eff == dc, go to IDLE.
  - Else if the step threshold is reached: dc ← dc+1, step counter ← 0, and go to IDLE if dc+1 == eff.
  - Otherwise the step counter increments.
- **DOWN:** mirror of UP.
  - If eff > dc, go to UP and clear the step counter.
  - Else if eff == dc, go to IDLE.
  - Else if the step threshold is reached: dc ← dc−1, step counter ← 0, and go to IDLE if dc−1 == eff.
  - Otherwise the step counter increments.

Rate changes:
- A new rate takes effect at the next tick.
- If the step counter is already at or above the new threshold, treat the threshold as reached.

Kill:
- While kill_s = 1, on every edge (not only ticks): dc ← 0, state ← IDLE, step counter ← 0.
- When kill_s falls, normal operation resumes from dc = 0.

Outputs:
- busy = (state is UP or DOWN).
- at_target = (dc == eff), registered alongside dc.
- dc never leaves the range 0..100, and no wrap-around is possible.

## Timing

- Reset values: dc = 0, period_start = 0, busy = 0, at_target = 1, period counter = 0, state = IDLE, step counter = 0, synchronizer flops = 0.
- period_start:
  - Set on each tick edge and cleared on the next edge.
  - The first pulse is in cycle 2^PERIOD_BITS after reset release, then every 2^PERIOD_BITS cycles.
  - A new dc value is visible in the same cycle as period_start.
- Input latency:
  - An input change is visible internally 2 edges later and is acted on at the next tick.
  - kill reaches dc = 0 at most 3 edges after kill rises.
- Ramp latency from IDLE to a target Δ away: 1 detection tick, then Δ·2^rate further ticks.
- Kill and tick on the same edge: kill wins.
- Target changing mid-ramp: the direction reversal costs one tick with dc held.

## Test plan

- **Reset and period pulses:** assert rst_n = 0 mid-run → all outputs take their reset values immediately. After release, period_start pulses at cycles 256, 512, 768 (PERIOD_BITS = 8).
- **Ramp up at rate 0:** target = 10, rate = 0, enable = 1 → busy rises at the first tick and dc climbs 1..10 on the next 10 ticks. On the tick where dc reaches 10: busy = 0, at_target = 1.
- **Clamp:** target = 120, rate = 0 → dc stops at 100, at_target = 1, and dc never exceeds 100.
- **Rate scaling:** rate = 2, target = 3 from dc = 0 → dc changes on the 4th, 8th and 12th ticks after the detection tick, and on no other tick.
- **Reversal:** while ramping toward 50, set target = 5 at dc = 20 → dc holds 20 for one tick, busy stays 1, then dc decrements once per step down to 5.
- **Kill and soft stop:**
  - kill = 1 at dc = 40 → dc = 0 within 3 cycles, busy = 0.
  - Release kill with enable = 1 → dc ramps from 0.
  - enable = 0 at dc = 30 → dc ramps down to 0 at the programmed rate.

Source files
------------

// File: rtl/pwm_duty_ramp.sv
// -----------------------------------------------------------------------------
// pwm_duty_ramp
//
// Soft-start / soft-stop sequencer for the duty-percent input of a downstream
// PWM generator. The block synchronizes its pad inputs and moves the duty one
// percent at a time toward the requested target. Each step waits 2^rate PWM
// periods. Every duty change, except an emergency kill, lands on a period
// boundary.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   target[6:0]  requested duty in percent (async); values above 100 clamp to 100
//   rate[R-1:0]  step interval selector, one step every 2^rate periods (async)
//   enable       0 forces the effective target to 0, a soft stop (async)
//   kill         emergency stop that forces dc to 0 on every edge (async)
//   dc[6:0]      current duty percent, 0..100 (registered)
//   period_start one-cycle pulse in the first cycle of each period (registered)
//   busy         high while ramping up or down (registered)
//   at_target    dc equals the effective target (registered with dc)
//   dbg_state    current sequencer state, for observation only
//
// Handshake: none. The inputs are level signals that the block samples through
// 2-flop synchronizers. The outputs are plain registered levels or pulses.
// -----------------------------------------------------------------------------
module pwm_duty_ramp #(
   parameter int PERIOD_BITS = 8,
   parameter int RATE_BITS   = 3
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [6:0]           target,
   input  logic [RATE_BITS-1:0] rate,
   input  logic                 enable,
   input  logic                 kill,
   output logic [6:0]           dc,
   output logic                 period_start,
   output logic                 busy,
   output logic                 at_target,
   output logic [1:0]           dbg_state
);

   // The step counter must hold up to 2^(2^RATE_BITS - 1) - 1.
   localparam int STEP_W = (1 << RATE_BITS) - 1;
   localparam logic [STEP_W-1:0] STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } state_t;

   // Synchronizer stages: _m is the metastable stage, _s is the stable stage.
   logic [6:0]           r_target_m, r_target_s;
   logic [RATE_BITS-1:0] r_rate_m,   r_rate_s;
   logic                 r_enable_m, r_enable_s;
   logic                 r_kill_m,   r_kill_s;

   logic [PERIOD_BITS-1:0] r_cnt;
   logic [STEP_W-1:0]      r_step;
   logic [6:0]             r_dc;
   state_t                 r_state;
   logic                   r_period_start;
   logic                   r_busy;
   logic                   r_at_target;

   logic [6:0]        w_tgt_clamp;
   logic [6:0]        w_eff;
   logic              w_tick;
   logic [STEP_W-1:0] w_thr;
   logic              w_step_hit;
   state_t            w_state_nxt;
   logic [6:0]        w_dc_nxt;
   logic [STEP_W-1:0] w_step_nxt;

   // ---------------------------------------------------------------------------
   // Input synchronizers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_target_m <= '0;
         r_target_s <= '0;
         r_rate_m   <= '0;
         r_rate_s   <= '0;
         r_enable_m <= 1'b0;
         r_enable_s <= 1'b0;
         r_kill_m   <= 1'b0;
         r_kill_s   <= 1'b0;
      end else begin
         r_target_m <= target;
         r_target_s <= r_target_m;
         r_rate_m   <= rate;
         r_rate_s   <= r_rate_m;
         r_enable_m <= enable;
         r_enable_s <= r_enable_m;
         r_kill_m   <= kill;
         r_kill_s   <= r_kill_m;
      end
   end

   // ---------------------------------------------------------------------------
   // Free-running period counter; the tick is the edge that wraps max -> 0
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + {{(PERIOD_BITS-1){1'b0}}, 1'b1};
      end
   end

   assign w_tick      = (r_cnt == {PERIOD_BITS{1'b1}});
   assign w_tgt_clamp = (r_target_s > 7'd100) ? 7'd100 : r_target_s;
   assign w_eff       = r_enable_s ? w_tgt_clamp : 7'd0;

   // For the largest rate, the shift wraps to 0 and the subtraction gives
   // all-ones, which equals 2^rate - 1.
   assign w_thr = (STEP_ONE << r_rate_s) - STEP_ONE;

   // Use >= so that a lowered rate fires at once when the counter has already
   // passed the new threshold.
   assign w_step_hit = (r_step >= w_thr);

   // ---------------------------------------------------------------------------
   // Sequencer: next-state and next-duty logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_dc_nxt    = r_dc;
      w_step_nxt  = r_step;
      if (r_kill_s) begin
         // kill overrides everything on every edge, including a tick.
         w_state_nxt = ST_IDLE;
         w_dc_nxt    = 7'd0;
         w_step_nxt  = '0;
      end else if (w_tick) begin
         case (r_state)
            ST_IDLE: begin
               w_step_nxt = '0;
               if (w_eff > r_dc) begin
                  w_state_nxt = ST_UP;
               end else if (w_eff < r_dc) begin
                  w_state_nxt = ST_DOWN;
               end
            end
            ST_UP: begin
               if (w_eff < r_dc) begin
                  // A reversal holds dc for this tick.
                  w_state_nxt = ST_DOWN;
                  w_step_nxt  = '0;
               end else if (w_eff == r_dc) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_step_hit) begin
                  w_dc_nxt   = r_dc + 7'd1;
                  w_step_nxt = '0;
                  if ((r_dc + 7'd1) == w_eff) begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_step_nxt = r_step + STEP_ONE;
               end
            end
            ST_DOWN: begin
               if (w_eff > r_dc) begin
                  w_state_nxt = ST_UP;
                  w_step_nxt  = '0;
               end else if (w_eff == r_dc) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_step_hit) begin
                  w_dc_nxt   = r_dc - 7'd1;
                  w_step_nxt = '0;
                  if ((r_dc - 7'd1) == w_eff) begin
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_step_nxt = r_step + STEP_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_step_nxt  = '0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= ST_IDLE;
         r_dc           <= 7'd0;
         r_step         <= '0;
         r_period_start <= 1'b0;
         r_busy         <= 1'b0;
         r_at_target    <= 1'b1;
      end else begin
         r_state        <= w_state_nxt;
         r_dc           <= w_dc_nxt;
         r_step         <= w_step_nxt;
         r_period_start <= w_tick;
         r_busy         <= (w_state_nxt != ST_IDLE);
         r_at_target    <= (w_dc_nxt == w_eff);
      end
   end

   assign dc           = r_dc;
   assign period_start = r_period_start;
   assign busy         = r_busy;
   assign at_target    = r_at_target;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_ramp
//
// Directed bench for pwm_duty_ramp with PERIOD_BITS = 8 and RATE_BITS = 3.
// All inputs are driven on the falling edge and all outputs are sampled on the
// falling edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_pwm_duty_ramp;

  logic       clk;
  logic       rst_n;
  logic [6:0] target;
  logic [2:0] rate;
  logic       enable;
  logic       kill;
  logic [6:0] dc;
  logic       period_start;
  logic       busy;
  logic       at_target;
  logic [1:0] dbg_state;

  int vectors;
  int miscompares;

  pwm_duty_ramp #(
    .PERIOD_BITS(8),
    .RATE_BITS  (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .target      (target),
    .rate        (rate),
    .enable      (enable),
    .kill        (kill),
    .dc          (dc),
    .period_start(period_start),
    .busy        (busy),
    .at_target   (at_target),
    .dbg_state   (dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge just after the next period_start pulse.
  task automatic next_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 400);
    if (!period_start) check("tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n  = 1'b0;
    target = 7'd0;
    rate   = 3'd0;
    enable = 1'b0;
    kill   = 1'b0;

    // reset values
    #23;
    check("rst_dc", dc, 0);
    check("rst_ps", period_start, 0);
    check("rst_busy", busy, 0);
    check("rst_at_target", at_target, 1);

    // ramp up from 0 to 10 at rate 0
    @(negedge clk);
    rst_n  = 1'b1;
    target = 7'd10;
    rate   = 3'd0;
    enable = 1'b1;
    next_tick();
    check("ramp_detect_busy", busy, 1);
    check("ramp_detect_dc", dc, 0);
    for (int i = 1; i <= 10; i++) begin
      next_tick();
      check("ramp_dc", dc, i);
      check("ramp_busy", busy, (i < 10) ? 1 : 0);
      check("ramp_at_target", at_target, (i == 10) ? 1 : 0);
    end

    // a target of 120 clamps to 100
    target = 7'd120;
    next_tick();
    check("clamp_detect_dc", dc, 10);
    check("clamp_detect_busy", busy, 1);
    for (int i = 1; i <= 90; i++) begin
      next_tick();
      check("clamp_dc", dc, 10 + i);
    end
    check("clamp_busy", busy, 0);
    check("clamp_at_target", at_target, 1);
    next_tick();
    check("clamp_hold_dc", dc, 100);

    // reset asserted mid-run, then the period pulse positions
    target = 7'd0;
    enable = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_dc", dc, 0);
    check("midrst_ps", period_start, 0);
    check("midrst_busy", busy, 0);
    check("midrst_at_target", at_target, 1);
    check("midrst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 768; n++) begin
      @(negedge clk);
      if (n == 255 || n == 257) check("ps_low", period_start, 0);
      if (n == 256 || n == 512 || n == 768) check("ps_pulse", period_start, 1);
    end

    // rate 2: dc steps on ticks 4, 8 and 12 after the detection tick
    target = 7'd3;
    rate   = 3'd2;
    enable = 1'b1;
    next_tick();
    check("rate_detect_busy", busy, 1);
    for (int t = 1; t <= 12; t++) begin
      next_tick();
      check("rate_dc", dc, t / 4);
    end
    check("rate_busy", busy, 0);

    // reversal while ramping toward 50
    target = 7'd50;
    rate   = 3'd0;
    next_tick();
    for (int i = 1; i <= 17; i++) begin
      next_tick();
      check("rev_up_dc", dc, 3 + i);
    end
    target = 7'd5;
    next_tick();
    check("rev_hold_dc", dc, 20);
    check("rev_hold_busy", busy, 1);
    for (int i = 1; i <= 15; i++) begin
      next_tick();
      check("rev_down_dc", dc, 20 - i);
    end
    check("rev_busy", busy, 0);
    check("rev_at_target", at_target, 1);

    // kill at dc = 40
    target = 7'd40;
    next_tick();
    for (int i = 1; i <= 35; i++) next_tick();
    check("kill_pre_dc", dc, 40);
    kill = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("kill_edge2_dc", dc, 40);
    @(negedge clk);
    check("kill_edge3_dc", dc, 0);
    check("kill_busy", busy, 0);
    kill = 1'b0;

    // resume from 0 after kill, then soft stop at dc = 30 with rate 1
    next_tick();
    check("resume_detect_dc", dc, 0);
    check("resume_detect_busy", busy, 1);
    for (int i = 1; i <= 30; i++) begin
      next_tick();
      check("resume_dc", dc, i);
    end
    enable = 1'b0;
    rate   = 3'd1;
    next_tick();
    check("stop_hold_dc", dc, 30);
    check("stop_hold_busy", busy, 1);
    for (int t = 1; t <= 60; t++) begin
      next_tick();
      check("stop_dc", dc, 30 - t / 2);
    end
    check("stop_busy", busy, 0);
    check("stop_at_target", at_target, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
